fifo_read_packer: RTL and testbench
===================================

# fifo_read_packer

Read-side consumer for the asynchronous FIFO. Lives entirely in the read clock domain and drains entries from the FIFO read port (`r_empty`, `r_data`, `r_inc`). It packs `PACK` consecutive entries into one wide word and presents that word downstream on a valid/ready handshake. It is the counterpart to the write-side producer logic and the default sink for `FIFO_top`.

## Interface
- `DATA_WIDTH`, default 4: FIFO entry width.
- `PACK`, default 4: FIFO entries per output word, ≥2.
- `r_clk` input, 1: read-domain clock; all state updates on its rising edge.
- `r_reset` input, 1: reset, synchronous, active-low.
- `r_empty` input, 1: FIFO empty flag.
- `r_data` input, `DATA_WIDTH`: FIFO read data. Combinational read, so it is valid whenever `r_empty` = 0.
- `r_inc` output, 1: pop request to the FIFO.
- `out_data` output, `DATA_WIDTH*PACK`: packed word. The first-popped entry sits in bits [DATA_WIDTH-1:0].
- `out_count` output, `CNT_W`: number of valid entries in `out_data`.
- `out_valid` output, 1: `out_data` and `out_count` are valid.
- `out_ready` input, 1: downstream accepts the word.

## Operation
- **Pop condition.** A pop occurs on an edge where `r_inc` = 1 and `r_empty` = 0.
- **Packing.** `r_data` is written into assembly slot `cnt`, then `cnt` increments.
- **Output register free.** `out_free` = !`out_valid` | `out_ready`.
- **Pop request.** `r_inc` = `r_reset` & !`r_empty` & !`flush_pend` & (`cnt` < PACK-1 | `out_free`). It is combinational and never asserts while `r_empty` = 1.
- **Final pop (`cnt` = PACK-1).**
  - The word {`r_data`, assembly[PACK-2:0]} is loaded straight into the output register.
  - `out_count` = PACK.
  - `out_valid` goes to 1 and `cnt` returns to 0.
- **Handshake.**
  - Transfer completes on an edge with `out_valid` & `out_ready`.
  - Once `out_valid` is 1, it stays 1 and `out_data` stays stable until accepted.
  - If a new word loads on the same edge as an accept, `out_valid` stays 1 with the new data.
- **Backpressure.**
  - With the output register occupied and `out_ready` = 0, the assembly fills to PACK-1 entries, then `r_inc` drops.
  - No FIFO entry is ever lost or duplicated.
- **Pop counter.** `cnt` is a modulo-PACK counter of width `CNT_W`. Its states are the fill levels 0..PACK-1; with flush compiled in, `flush_pend` adds a FLUSH state.
- **Reset (`r_reset` = 0 at an edge).**
  - Sets `cnt` = 0, `out_valid` = 0, `out_data` = 0, `out_count` = 0, `flush_pend` = 0.
  - `r_inc` is held at 0 during reset.
  - Reset mid-word discards the partial word. Entries already popped are lost by design.

## Timing
- **Latency.** `out_valid` rises on the edge of the final pop and is seen in the cycle after it.
- **Throughput.** Sustained rate is one word per PACK cycles when the FIFO stays non-empty and `out_ready` = 1.
- **Empty FIFO.** A cycle with `r_empty` = 1 holds `cnt` and the assembly contents.
- **Clock domain.** Nothing crosses clock domains inside this block. `r_empty` is already synchronized by the FIFO.

## Configuration
- **`FIFO_PACK_FLUSH_EN` defined:**
  - Adds input `flush` (1 bit).
  - A `flush` = 1 at an edge with `cnt` > 0 sets `flush_pend`. A pop on that same edge is included first.
  - If that pop completes the word, a normal full word is emitted and `flush_pend` stays 0.
  - While `flush_pend` = 1, `r_inc` = 0.
  - At the first edge with `out_free`: the partial word is loaded zero-padded above slot `cnt`-1, with `out_count` = `cnt`. Then `cnt` = 0 and `flush_pend` = 0.
  - `flush` with `cnt` = 0 and no pop is ignored.
- **Macro not defined:** no `flush` port, no `flush_pend`, and `out_count` is always PACK when `out_valid` = 1.

## Structure
- **Shared package `fifo_pkg`:** `DATA_WIDTH`, `PACK`, `CNT_W` = $clog2(PACK+1), and the packed-word typedef `pack_word_t`.
- **Sub-module `pack_out_stage`:** the output register plus valid/ready hold logic, with load/accept inputs. The assembly counter and pop logic stay in the top.

## Test plan
All scenarios use DATA_WIDTH = 4 and PACK = 4.
- **Reset:** `r_reset` = 0 for 2 cycles with `r_empty` = 0 → `r_inc` = 0, `out_valid` = 0, `out_data` = 16'h0000, `out_count` = 0.
- **Basic pack:** pop 0x1, 0x2, 0x3, 0x4 back-to-back with `out_ready` = 1 → `out_valid` = 1 one cycle after the 4th pop, `out_data` = 16'h4321, `out_count` = 4. Next word follows 4 cycles later.
- **Backpressure:** 8 entries 0x1..0x8 available, `out_ready` = 0 → first word 16'h4321 is held, `r_inc` drops after 0x5..0x7 are popped. Raising `out_ready` → 16'h8765 appears; no entries lost.
- **Empty gaps:** `r_empty` toggles 1/0 each cycle while feeding 0xA, 0xB, 0xC, 0xD → pops occur only while `r_empty` = 0, result 16'hDCBA.
- **Reset mid-word:** `r_reset` = 0 pulse after 2 pops → `cnt` = 0, no output. Next pops 0x5..0x8 → 16'h8765.
- **Flush (`FIFO_PACK_FLUSH_EN`):** pop 0xA, 0xB, then `flush` = 1 → `out_data` = 16'h00BA, `out_count` = 2. A `flush` with `cnt` = 0 produces no output.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared configuration and types for the read-side FIFO packer.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH = 4;
    localparam int unsigned PACK       = 4;
    localparam int unsigned CNT_W      = $clog2(PACK + 1);
    localparam int unsigned WORD_W     = DATA_WIDTH * PACK;
    localparam int unsigned ASM_W      = DATA_WIDTH * (PACK - 1);

    typedef logic [WORD_W-1:0] pack_word_t;
    typedef logic [ASM_W-1:0]  asm_word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Keeps slots below `fill` and zeroes the rest, so stale data from an
    // earlier word never leaks into a partial word.
    function automatic pack_word_t pad_partial(input asm_word_t assembly, input cnt_t fill);
        pack_word_t word;
        word = '0;
        for (int i = 0; i < int'(PACK) - 1; i++) begin
            if (i < int'(fill)) begin
                word[i*DATA_WIDTH +: DATA_WIDTH] = assembly[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return word;
    endfunction

endpackage

// File: rtl/pack_out_stage.sv
// Output register for the packer: holds a word stable under valid/ready until accepted.
module pack_out_stage
    import fifo_pkg::*;
(
    input  logic       r_clk,
    input  logic       r_reset,
    input  logic       load,
    input  pack_word_t load_data,
    input  cnt_t       load_count,
    input  logic       out_ready,
    output pack_word_t out_data,
    output cnt_t       out_count,
    output logic       out_valid
);

    // The packer only loads when the register is free, so a load always wins
    // over an accept on the same edge.
    always_ff @(posedge r_clk) begin
        if (!r_reset) begin
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_count <= load_count;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_read_packer.sv
// Drains the async FIFO read port and packs PACK entries into one output word.
// Define FIFO_PACK_FLUSH_EN to add the `flush` input for emitting partial words.
module fifo_read_packer
    import fifo_pkg::*;
(
    input  logic                  r_clk,
    input  logic                  r_reset,
`ifdef FIFO_PACK_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  r_empty,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_inc,
    output pack_word_t            out_data,
    output cnt_t                  out_count,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam cnt_t LastSlot = cnt_t'(PACK - 1);
    localparam cnt_t FullCnt  = cnt_t'(PACK);

    logic       out_free;
    logic       pop;
    logic       final_pop;
    logic       flush_load;
    logic       load;
    cnt_t       cnt;
    asm_word_t  assembly;
    pack_word_t load_data;
    cnt_t       load_count;

    assign out_free = !out_valid || out_ready;

`ifdef FIFO_PACK_FLUSH_EN
    logic flush_pend;

    assign r_inc      = r_reset && !r_empty && !flush_pend && ((cnt < LastSlot) || out_free);
    assign flush_load = flush_pend && out_free;

    // A pop on the flush edge lands first; if it completes the word the
    // normal full-word path already emits it and no flush is pending.
    always_ff @(posedge r_clk) begin
        if (!r_reset) begin
            flush_pend <= 1'b0;
        end else if (flush_load) begin
            flush_pend <= 1'b0;
        end else if (flush && !final_pop && ((cnt != '0) || pop)) begin
            flush_pend <= 1'b1;
        end
    end
`else
    assign r_inc      = r_reset && !r_empty && ((cnt < LastSlot) || out_free);
    assign flush_load = 1'b0;
`endif

    assign pop       = r_inc && !r_empty;
    assign final_pop = pop && (cnt == LastSlot);
    assign load      = final_pop || flush_load;

    always_comb begin
        load_data  = pad_partial(assembly, cnt);
        load_count = cnt;
        if (final_pop) begin
            load_data  = {r_data, assembly};
            load_count = FullCnt;
        end
    end

    always_ff @(posedge r_clk) begin
        if (!r_reset) begin
            cnt      <= '0;
            assembly <= '0;
        end else begin
            if (final_pop || flush_load) begin
                cnt <= '0;
            end else if (pop) begin
                cnt <= cnt + cnt_t'(1);
            end
            for (int i = 0; i < int'(PACK) - 1; i++) begin
                if (pop && !final_pop && (cnt == cnt_t'(i))) begin
                    assembly[i*DATA_WIDTH +: DATA_WIDTH] <= r_data;
                end
            end
        end
    end

    pack_out_stage u_out_stage (
        .r_clk      (r_clk),
        .r_reset    (r_reset),
        .load       (load),
        .load_data  (load_data),
        .load_count (load_count),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_valid  (out_valid)
    );

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer (DATA_WIDTH = 4, PACK = 4) with a queue-based FIFO model.
module tb_fifo_read_packer;

    logic        r_clk;
    logic        r_reset;
    logic        r_empty;
    logic [3:0]  r_data;
    logic        r_inc;
    logic [15:0] out_data;
    logic [2:0]  out_count;
    logic        out_valid;
    logic        out_ready;
`ifdef FIFO_PACK_FLUSH_EN
    logic        flush;
`endif

    fifo_read_packer dut (
        .r_clk     (r_clk),
        .r_reset   (r_reset),
`ifdef FIFO_PACK_FLUSH_EN
        .flush     (flush),
`endif
        .r_empty   (r_empty),
        .r_data    (r_data),
        .r_inc     (r_inc),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned pops        = 0;
    bit          bad_inc     = 1'b0;
    bit          gap_mode    = 1'b0;
    bit          gap_phase   = 1'b0;
    logic [3:0]  fq[$];
    logic [15:0] acc_data[$];
    logic [2:0]  acc_cnt[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive FIFO inputs at negedge, record pop/accept, update model at posedge.
    task automatic cycle();
        bit pop_now;
        @(negedge r_clk);
        r_empty = (fq.size() == 0) || (gap_mode && gap_phase);
        r_data  = (fq.size() != 0) ? fq[0] : 4'h0;
        gap_phase = !gap_phase;
        #1;
        if (r_inc && r_empty) bad_inc = 1'b1;
        pop_now = r_inc && !r_empty;
        if (out_valid && out_ready) begin
            acc_data.push_back(out_data);
            acc_cnt.push_back(out_count);
        end
        @(posedge r_clk);
        if (pop_now) begin
            void'(fq.pop_front());
            pops++;
        end
        #1;
    endtask

    task automatic push_range(input int first, input int last);
        for (int v = first; v <= last; v++) fq.push_back(4'(v));
    endtask

    initial begin
        r_reset   = 1'b0;
        r_empty   = 1'b1;
        r_data    = 4'h0;
        out_ready = 1'b0;
`ifdef FIFO_PACK_FLUSH_EN
        flush     = 1'b0;
`endif

        // Reset with a non-empty FIFO: nothing popped, outputs cleared.
        fq.push_back(4'h9);
        repeat (2) cycle();
        check("rst_r_inc", 32'(r_inc), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'h0000);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_no_pop", pops, 0);
        fq.delete();
        r_reset = 1'b1;

        // Basic pack, two back-to-back words.
        out_ready = 1'b1;
        push_range(1, 8);
        repeat (3) cycle();
        check("basic_not_yet", 32'(out_valid), 32'd0);
        cycle();
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_data", 32'(out_data), 32'h4321);
        check("basic_count", 32'(out_count), 32'd4);
        repeat (3) cycle();
        check("basic_gap", 32'(out_valid), 32'd0);
        cycle();
        check("basic_data2", 32'(out_data), 32'h8765);
        cycle();
        check("basic_acc_n", acc_data.size(), 2);
        if (acc_data.size() == 2) begin
            check("basic_acc0", 32'(acc_data[0]), 32'h4321);
            check("basic_acc1", 32'(acc_data[1]), 32'h8765);
        end
        acc_data.delete();
        acc_cnt.delete();

        // Backpressure: word held, assembly fills to three entries, then stalls.
        out_ready = 1'b0;
        push_range(1, 8);
        repeat (10) cycle();
        check("bp_left", fq.size(), 1);
        check("bp_hold_data", 32'(out_data), 32'h4321);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_r_inc_low", 32'(r_inc), 32'd0);
        out_ready = 1'b1;
        cycle();
        check("bp_swap_valid", 32'(out_valid), 32'd1);
        check("bp_swap_data", 32'(out_data), 32'h8765);
        cycle();
        check("bp_acc_n", acc_data.size(), 2);
        if (acc_data.size() == 2) begin
            check("bp_acc0", 32'(acc_data[0]), 32'h4321);
            check("bp_acc1", 32'(acc_data[1]), 32'h8765);
        end
        check("bp_drained", fq.size(), 0);
        check("bp_idle", 32'(out_valid), 32'd0);
        acc_data.delete();
        acc_cnt.delete();

        // Empty flag toggling every cycle.
        gap_mode  = 1'b1;
        gap_phase = 1'b1;
        fq.push_back(4'hA);
        fq.push_back(4'hB);
        fq.push_back(4'hC);
        fq.push_back(4'hD);
        repeat (10) cycle();
        gap_mode = 1'b0;
        check("gap_acc_n", acc_data.size(), 1);
        if (acc_data.size() == 1) begin
            check("gap_data", 32'(acc_data[0]), 32'hDCBA);
            check("gap_count", 32'(acc_cnt[0]), 32'd4);
        end
        check("gap_no_pop_when_empty", 32'(bad_inc), 32'd0);
        acc_data.delete();
        acc_cnt.delete();

        // Reset mid-word discards the partial word.
        fq.push_back(4'h1);
        fq.push_back(4'h2);
        repeat (3) cycle();
        check("rmid_no_out", 32'(out_valid), 32'd0);
        r_reset = 1'b0;
        cycle();
        r_reset = 1'b1;
        push_range(5, 8);
        repeat (4) cycle();
        check("rmid_valid", 32'(out_valid), 32'd1);
        check("rmid_data", 32'(out_data), 32'h8765);
        check("rmid_count", 32'(out_count), 32'd4);
        cycle();
        acc_data.delete();
        acc_cnt.delete();

`ifdef FIFO_PACK_FLUSH_EN
        // Flush a two-entry partial word, then a flush on an empty assembly.
        fq.push_back(4'hA);
        fq.push_back(4'hB);
        repeat (3) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        check("flush_valid", 32'(out_valid), 32'd1);
        check("flush_data", 32'(out_data), 32'h00BA);
        check("flush_count", 32'(out_count), 32'd2);
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (2) cycle();
        check("flush_empty_ignored", 32'(out_valid), 32'd0);
        check("flush_empty_acc", acc_data.size(), 1);
`endif

        check("total_pops", pops, 8 + 8 + 4 + 2 + 4
`ifdef FIFO_PACK_FLUSH_EN
            + 2
`endif
        );

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
